lcd12864_rx: RTL and testbench

Receive-side model of the 12864 character-LCD parallel bus (ST7920-style, 8-bit, basic instruction set). It samples `rs`/`rw`/`en`/`dat` from the existing LCD writer, decodes instructions, and maintains a 64-byte text DDRAM with the controller's interleaved row mapping. Status reads on the bus return the busy flag and address counter. A linear screen read port and display-control flags feed on-chip checking or a mirror renderer.

---
 rtl/lcd12864_rx_if.sv | 28 ++
 rtl/lcd12864_rx.sv | 200 ++++++++++++++++++++
 tb/tb_lcd12864_rx.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd12864_rx_if.sv
// 12864 LCD parallel bus bundle.
// The writer drives rs/rw/en/dat; the receiver answers reads on dat_o/dat_oe.
interface lcd12864_rx_if;
    logic       rs;
    logic       rw;
    logic       en;
    logic [7:0] dat;
    logic [7:0] dat_o;
    logic       dat_oe;

    modport master (
        output rs,
        output rw,
        output en,
        output dat,
        input  dat_o,
        input  dat_oe
    );

    modport slave (
        input  rs,
        input  rw,
        input  en,
        input  dat,
        output dat_o,
        output dat_oe
    );
endinterface

// File: rtl/lcd12864_rx.sv
// Receive-side model of an ST7920-style 12864 LCD controller (8-bit bus).
// Decodes the basic instruction set into a 64-byte interleaved text DDRAM.
module lcd12864_rx #(
    parameter int unsigned BUSY_CYCLES  = 72,
    parameter int unsigned CLEAR_CYCLES = 1600
) (
    input  logic       clk,
    input  logic       rst,
    lcd12864_rx_if.slave bus,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned MAXC =
        (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    // Synchroniser chains, index 0 = stage 1 .. index 2 = stage 3.
    logic [2:0]      rs_q;
    logic [2:0]      rw_q;
    logic [2:0]      en_q;
    logic [2:0][7:0] dat_q;
    logic            strobe;

    // Captured access, executed one cycle after the strobe is seen.
    logic       acc_v;
    logic       acc_rs;
    logic       acc_rw;
    logic [7:0] acc_dat;

    // Controller state; ptr is {ac, hf}.
    logic [5:0]    ptr;
    logic [5:0]    ptr_nxt;
    logic          inc;
    logic          ext;
    logic [CW-1:0] cnt;
    logic          sw_act;
    logic [5:0]    sw_idx;

    logic [7:0] mem [64];
    logic [5:0] scr_idx;

    // Access classification for the captured strobe.
    logic is_stat;
    logic take;
    logic drop_acc;
    logic is_dwr;
    logic is_drd;
    logic is_ins;
    logic is_clr;

    assign strobe   = ~en_q[1] & en_q[2];
    assign busy     = (cnt != '0);
    assign is_stat  = acc_v & ~acc_rs & acc_rw;
    assign take     = acc_v & ~is_stat & ~busy;
    assign drop_acc = acc_v & ~is_stat & busy;
    assign is_dwr   = take & acc_rs & ~acc_rw;
    assign is_drd   = take & acc_rs & acc_rw;
    assign is_ins   = take & ~acc_rs & ~acc_rw;
    assign is_clr   = is_ins & ~ext & (acc_dat == 8'h01);
    assign ptr_nxt  = inc ? (ptr + 6'd1) : (ptr - 6'd1);

    // Screen row r, column c lives at DDRAM byte {r[0], r[1], c}.
    assign scr_idx = {rd_addr[4], rd_addr[5], rd_addr[3:0]};

    // Bus read drive follows the stage-2 strobe and direction.
    assign bus.dat_oe = en_q[1] & rw_q[1];
    assign bus.dat_o  = !bus.dat_oe ? 8'h00 :
                        rs_q[1]     ? mem[ptr] :
                                      {busy, 1'b0, ptr};

    // Bring the asynchronous bus into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q  <= '0;
            rw_q  <= '0;
            en_q  <= '0;
            dat_q <= '0;
        end else begin
            rs_q  <= {rs_q[1:0], bus.rs};
            rw_q  <= {rw_q[1:0], bus.rw};
            en_q  <= {en_q[1:0], bus.en};
            dat_q <= {dat_q[1:0], bus.dat};
        end
    end

    // Latch the completed access on the en falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_v   <= 1'b0;
            acc_rs  <= 1'b0;
            acc_rw  <= 1'b0;
            acc_dat <= 8'h00;
        end else begin
            acc_v   <= strobe;
            acc_rs  <= rs_q[2];
            acc_rw  <= rw_q[2];
            acc_dat <= dat_q[2];
        end
    end

    // Execute accesses: busy timer, address counter, mode flags, sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 6'd0;
            inc       <= 1'b1;
            ext       <= 1'b0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            cnt       <= '0;
            sw_act    <= 1'b0;
            sw_idx    <= 6'd0;
            overrun   <= 1'b0;
        end else begin
            overrun <= drop_acc;
            if (busy) begin
                cnt <= cnt - CW'(1);
            end
            if (sw_act) begin
                sw_idx <= sw_idx + 6'd1;
                if (sw_idx == 6'd63) begin
                    sw_act <= 1'b0;
                end
            end
            if (take) begin
                cnt <= is_clr ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES);
            end
            if (is_dwr || is_drd) begin
                ptr <= ptr_nxt;
            end
            if (is_ins) begin
                if (ext) begin
                    // Extended set: only function set is honoured.
                    if (acc_dat[7:5] == 3'b001) begin
                        ext <= acc_dat[2];
                    end
                end else begin
                    unique case (1'b1)
                        acc_dat[7]: begin
                            ptr <= {acc_dat[4:0], 1'b0};
                        end
                        acc_dat[7:6] == 2'b01: begin
                        end
                        acc_dat[7:5] == 3'b001: begin
                            ext <= acc_dat[2];
                        end
                        acc_dat[7:4] == 4'b0001: begin
                        end
                        acc_dat[7:3] == 5'b00001: begin
                            disp_on   <= acc_dat[2];
                            cursor_on <= acc_dat[1];
                            blink_on  <= acc_dat[0];
                        end
                        acc_dat[7:2] == 6'b000001: begin
                            inc <= acc_dat[1];
                        end
                        acc_dat[7:1] == 7'b0000001: begin
                            ptr <= 6'd0;
                        end
                        acc_dat == 8'h01: begin
                            ptr    <= 6'd0;
                            inc    <= 1'b1;
                            sw_act <= 1'b1;
                            sw_idx <= 6'd0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // DDRAM writes: clear sweep has priority; stop writing under reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sw_act) begin
                mem[sw_idx] <= 8'h20;
            end else if (is_dwr) begin
                mem[ptr] <= acc_dat;
            end
        end
    end

    // Registered screen-linear read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[scr_idx];
        end
    end

endmodule

// File: tb/tb_lcd12864_rx.sv
// Directed bench for lcd12864_rx.
// Drives the LCD bus with timed strobes and checks screen, status and busy.
module tb_lcd12864_rx;

    localparam int BUSY_C  = 72;
    localparam int CLEAR_C = 1600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] rd_data;
    logic       disp_on;
    logic       cursor_on;
    logic       blink_on;
    logic       busy;
    logic       overrun;

    lcd12864_rx_if bus();

    lcd12864_rx #(
        .BUSY_CYCLES (BUSY_C),
        .CLEAR_CYCLES(CLEAR_C)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .disp_on  (disp_on),
        .cursor_on(cursor_on),
        .blink_on (blink_on),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pcyc = 0;
    int drop = 0;
    int ovr_cnt = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    logic busy_prev = 1'b0;
    logic [7:0] exp_scr [64];

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [7:0] st;
        logic [2:0] fl;
    } vec_t;

    vec_t tbl [23];

    // Posedge counter; busy edges and overrun pulses observed at negedge.
    always @(posedge clk) pcyc <= pcyc + 1;

    always @(negedge clk) begin
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (busy && !busy_prev) rise_cyc <= pcyc;
        if (!busy && busy_prev) fall_cyc <= pcyc;
        busy_prev <= busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic access(input logic r_s, input logic r_w,
                          input logic [7:0] d,
                          output logic [7:0] rv, output logic oe);
        @(negedge clk);
        bus.rs  = r_s;
        bus.rw  = r_w;
        bus.dat = d;
        bus.en  = 1'b1;
        repeat (3) @(negedge clk);
        rv = bus.dat_o;
        oe = bus.dat_oe;
        bus.en = 1'b0;
        drop = pcyc;
        repeat (5) @(negedge clk);
        bus.rw = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=1 want 0");
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic r_s, input logic [7:0] d);
        logic [7:0] rv;
        logic       oe;
        access(r_s, 1'b0, d, rv, oe);
        wait_idle();
    endtask

    task automatic status(output logic [7:0] st);
        logic oe;
        access(1'b0, 1'b1, 8'h00, st, oe);
        chk("status_oe", oe, 1'b1);
    endtask

    task automatic rd_scr(input logic [5:0] a, output logic [7:0] v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic check_screen(input string nm);
        logic [7:0] v;
        for (int a = 0; a < 64; a++) begin
            rd_scr(6'(a), v);
            chk($sformatf("%s[%0d]", nm, a), v, exp_scr[a]);
        end
    endtask

    initial begin
        logic [7:0] st;
        logic [7:0] v;
        logic       oe;
        logic [5:0] sa;
        int         d0;
        int         ob;
        int         nbl;
        int         trans;

        tbl[0]  = '{1'b0, 8'h9F, 8'h3E, 3'b100};
        tbl[1]  = '{1'b1, 8'h58, 8'h3F, 3'b100};
        tbl[2]  = '{1'b1, 8'h59, 8'h00, 3'b100};
        tbl[3]  = '{1'b1, 8'h5A, 8'h01, 3'b100};
        tbl[4]  = '{1'b0, 8'h0F, 8'h01, 3'b111};
        tbl[5]  = '{1'b0, 8'h0A, 8'h01, 3'b010};
        tbl[6]  = '{1'b0, 8'h0C, 8'h01, 3'b100};
        tbl[7]  = '{1'b0, 8'h02, 8'h00, 3'b100};
        tbl[8]  = '{1'b0, 8'h85, 8'h0A, 3'b100};
        tbl[9]  = '{1'b0, 8'hE5, 8'h0A, 3'b100};
        tbl[10] = '{1'b0, 8'h04, 8'h0A, 3'b100};
        tbl[11] = '{1'b0, 8'h81, 8'h02, 3'b100};
        tbl[12] = '{1'b1, 8'h70, 8'h01, 3'b100};
        tbl[13] = '{1'b1, 8'h71, 8'h00, 3'b100};
        tbl[14] = '{1'b0, 8'h06, 8'h00, 3'b100};
        tbl[15] = '{1'b0, 8'h34, 8'h00, 3'b100};
        tbl[16] = '{1'b0, 8'h08, 8'h00, 3'b100};
        tbl[17] = '{1'b0, 8'h87, 8'h00, 3'b100};
        tbl[18] = '{1'b0, 8'h01, 8'h00, 3'b100};
        tbl[19] = '{1'b0, 8'h30, 8'h00, 3'b100};
        tbl[20] = '{1'b0, 8'h10, 8'h00, 3'b100};
        tbl[21] = '{1'b0, 8'h40, 8'h00, 3'b100};
        tbl[22] = '{1'b0, 8'h03, 8'h00, 3'b100};

        bus.rs  = 1'b0;
        bus.rw  = 1'b0;
        bus.en  = 1'b0;
        bus.dat = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_oe", bus.dat_oe, 1'b0);
        chk("rst_dat_o", bus.dat_o, 8'h00);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_flags", {disp_on, cursor_on, blink_on}, 3'b000);
        rst = 1'b0;
        status(st);
        chk("rst_status", st, 8'h00);

        // Init and row 0.
        wr(1'b0, 8'h30);
        wr(1'b0, 8'h0C);
        wr(1'b0, 8'h06);
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) wr(1'b1, 8'(8'h41 + i));
        chk("init_flags", {disp_on, cursor_on, blink_on}, 3'b100);
        for (int a = 0; a < 64; a++) exp_scr[a] = 8'h20;
        for (int a = 0; a < 16; a++) exp_scr[a] = 8'(8'h41 + a);
        check_screen("row0");

        // Row mapping.
        wr(1'b0, 8'h90);
        for (int i = 0; i < 16; i++) wr(1'b1, 8'h31);
        wr(1'b0, 8'h88);
        for (int i = 0; i < 16; i++) wr(1'b1, 8'h32);
        wr(1'b0, 8'h98);
        for (int i = 0; i < 16; i++) wr(1'b1, 8'h33);
        for (int a = 16; a < 32; a++) exp_scr[a] = 8'h31;
        for (int a = 32; a < 48; a++) exp_scr[a] = 8'h32;
        for (int a = 48; a < 64; a++) exp_scr[a] = 8'h33;
        check_screen("rows");

        // Instruction table: status and flags after each access.
        foreach (tbl[k]) begin
            wr(tbl[k].rs, tbl[k].d);
            status(st);
            chk($sformatf("tbl%0d_status", k), st, tbl[k].st);
            chk($sformatf("tbl%0d_flags", k),
                {disp_on, cursor_on, blink_on}, tbl[k].fl);
        end
        exp_scr[62] = 8'h58;
        exp_scr[63] = 8'h59;
        exp_scr[0]  = 8'h5A;
        exp_scr[2]  = 8'h70;
        exp_scr[1]  = 8'h71;
        check_screen("table");

        // Data reads advance the address and set busy.
        wr(1'b0, 8'h80);
        access(1'b1, 1'b1, 8'h00, v, oe);
        chk("drd0_oe", oe, 1'b1);
        chk("drd0_data", v, 8'h5A);
        wait_idle();
        status(st);
        chk("drd0_status", st, 8'h01);
        access(1'b1, 1'b1, 8'h00, v, oe);
        chk("drd1_data", v, 8'h71);
        wait_idle();
        status(st);
        chk("drd1_status", st, 8'h02);

        // Ordinary busy latency and length.
        access(1'b0, 1'b0, 8'h80, v, oe);
        d0 = drop;
        wait_idle();
        chk("busy_lat", rise_cyc - d0, 4);
        chk("busy_len", fall_cyc - rise_cyc, BUSY_C);

        // Clear with an overrunning data strobe mid-way.
        ob = ovr_cnt;
        access(1'b0, 1'b0, 8'h01, v, oe);
        d0 = drop;
        while (pcyc < d0 + 100) @(negedge clk);
        access(1'b1, 1'b0, 8'h4B, v, oe);
        repeat (2) @(negedge clk);
        chk("ovr_pulse", ovr_cnt - ob, 1);
        status(st);
        chk("clr_status_busy", st, 8'h80);
        repeat (2) @(negedge clk);
        chk("ovr_no_status", ovr_cnt - ob, 1);
        wait_idle();
        chk("clr_lat", rise_cyc - d0, 4);
        chk("clr_len", fall_cyc - rise_cyc, CLEAR_C);
        status(st);
        chk("clr_status_idle", st, 8'h00);
        for (int a = 0; a < 64; a++) exp_scr[a] = 8'h20;
        check_screen("clr");

        // Reset in the middle of a clear.
        for (int i = 0; i < 64; i++) wr(1'b1, 8'h41);
        rd_scr(6'd37, v);
        chk("fill_A", v, 8'h41);
        access(1'b0, 1'b0, 8'h01, v, oe);
        d0 = drop;
        while (pcyc < d0 + 24) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_overrun", overrun, 1'b0);
        chk("mrst_oe", bus.dat_oe, 1'b0);
        chk("mrst_dat_o", bus.dat_o, 8'h00);
        chk("mrst_rd_data", rd_data, 8'h00);
        chk("mrst_flags", {disp_on, cursor_on, blink_on}, 3'b000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_busy_after", busy, 1'b0);
        status(st);
        chk("mrst_status", st, 8'h00);
        nbl = 0;
        trans = 0;
        for (int i = 0; i < 64; i++) begin
            sa = {i[4], i[5], i[3:0]};
            rd_scr(sa, v);
            if (i < 10) chk($sformatf("mrst_cleared%0d", i), v, 8'h20);
            if (i >= 30) chk($sformatf("mrst_kept%0d", i), v, 8'h41);
            if (v == 8'h20) nbl++;
            if (i > 0 && v == 8'h20 && nbl != i + 1) trans++;
        end
        chk("mrst_prefix", trans, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
